lc_dco_cal: RTL and testbench

Calibration and characterisation controller for the LC DCO's `SW_Width`-bit capacitor-switch code. It runs in the `ref_clk` domain and drives the DCO `sw` bus. For every trial code it waits a settle interval, then counts DCO ticks over a fixed reference window. In SAR mode it binary-searches the code against a target count; in sweep mode it steps every code and reports each measurement. It sits beside `lc_dco` inside `pll_ss` and replaces hand-stepped code sequences at bring-up.

---
 rtl/lc_dco_cal.sv | 154 +++++++++++++++
 tb/tb_lc_dco_cal.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc_dco_cal.sv
// lc_dco_cal: LC DCO capacitor-code calibration and characterisation controller.
// For every trial code it waits a settle interval, counts divided-DCO ticks over a
// fixed reference window, then either binary-searches the code against a target
// count (SAR mode) or steps through every code and reports each measurement (sweep).
module lc_dco_cal #(
   parameter int SW_Width      = 8,
   parameter int CNT_Width     = 16,
   parameter int WIN_CYCLES    = 1024,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                 ref_clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 mode,
   input  logic [CNT_Width-1:0] target_cnt,
   input  logic                 dco_tick,
   output logic [SW_Width-1:0]  sw,
   output logic                 busy,
   output logic                 done,
   output logic                 meas_valid,
   output logic [CNT_Width-1:0] meas_cnt,
   output logic [SW_Width-1:0]  meas_code
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETTLE  = 3'd1;
   localparam logic [2:0] ST_MEASURE = 3'd2;
   localparam logic [2:0] ST_DECIDE  = 3'd3;
   localparam logic [2:0] ST_FINISH  = 3'd4;

   // One down-counter serves both the settle and the measurement interval.
   localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int BI_W    = (SW_Width > 1) ? $clog2(SW_Width) : 1;

   localparam logic [TMR_W-1:0]    SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0]    WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);
   localparam logic [SW_Width-1:0] SAR_FIRST   = SW_Width'(1) << (SW_Width - 1);
   localparam logic [BI_W-1:0]     BIT_TOP     = BI_W'(SW_Width - 1);

   logic [2:0]           state;
   logic [TMR_W-1:0]     timer;
   logic [CNT_Width-1:0] cnt;
   logic [BI_W-1:0]      bit_idx;
   logic [BI_W-1:0]      bit_idx_m1;
   logic                 mode_q;
   logic [CNT_Width-1:0] target_q;
   logic [SW_Width-1:0]  sar_code_n;
   logic                 sar_last;

   // Tick counter holds at all-ones rather than wrapping to a misleading small value.
   function automatic logic [CNT_Width-1:0] sat_inc(input logic [CNT_Width-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign bit_idx_m1 = bit_idx - BI_W'(1);
   assign sar_last   = (bit_idx == '0);

   // SAR step: a count above target means the DCO runs fast, so the bit under
   // test stays set (more capacitance); then the next lower bit is tried.
   always_comb begin
      sar_code_n = sw;
      if (!(cnt > target_q)) sar_code_n[bit_idx] = 1'b0;
      if (!sar_last) sar_code_n[bit_idx_m1] = 1'b1;
   end

   // Run sequencer: trial settle/measure/decide loop plus registered outputs.
   always_ff @(posedge ref_clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         timer      <= '0;
         cnt        <= '0;
         bit_idx    <= '0;
         mode_q     <= 1'b0;
         target_q   <= '0;
         sw         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         meas_valid <= 1'b0;
         meas_cnt   <= '0;
         meas_code  <= '0;
      end else begin
         done       <= 1'b0;
         meas_valid <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            sw    <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     mode_q   <= mode;
                     target_q <= target_cnt;
                     sw       <= mode ? '0 : SAR_FIRST;
                     bit_idx  <= BIT_TOP;
                     timer    <= SETTLE_LOAD;
                     busy     <= 1'b1;
                     state    <= ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (timer == '0) begin
                     timer <= WIN_LOAD;
                     cnt   <= '0;
                     state <= ST_MEASURE;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               ST_MEASURE: begin
                  if (dco_tick) cnt <= sat_inc(cnt);
                  if (timer == '0) begin
                     state <= ST_DECIDE;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               ST_DECIDE: begin
                  meas_valid <= 1'b1;
                  meas_cnt   <= cnt;
                  meas_code  <= sw;
                  if (!mode_q) begin
                     sw <= sar_code_n;
                     if (sar_last) begin
                        state <= ST_FINISH;
                     end else begin
                        bit_idx <= bit_idx_m1;
                        timer   <= SETTLE_LOAD;
                        state   <= ST_SETTLE;
                     end
                  end else begin
                     if (&sw) begin
                        state <= ST_FINISH;
                     end else begin
                        sw    <= sw + 1'b1;
                        timer <= SETTLE_LOAD;
                        state <= ST_SETTLE;
                     end
                  end
               end
               ST_FINISH: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lc_dco_cal.sv
// tb_lc_dco_cal: scoreboard bench for lc_dco_cal (SW_Width=4, WIN=16, SETTLE=2).
// The DCO model emits rate(code) ticks in every 16 consecutive cycles, with
// rate(code) = min(16, 20 - code), since a 16-cycle window holds at most 16 ticks.
module tb_lc_dco_cal;

   localparam int SW_W  = 4;
   localparam int CNT_W = 16;
   localparam int WIN   = 16;
   localparam int SET   = 2;
   localparam int T     = SET + WIN + 1;

   typedef struct {
      int code;
      int cnt;
   } meas_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic             mode;
   logic [CNT_W-1:0] target_cnt;
   logic             dco_tick;
   logic [SW_W-1:0]  sw;
   logic             busy;
   logic             done;
   logic             meas_valid;
   logic [CNT_W-1:0] meas_cnt;
   logic [SW_W-1:0]  meas_code;

   logic             s_start;
   logic [2:0]       s_target;
   logic [SW_W-1:0]  s_sw;
   logic             s_busy;
   logic             s_done;
   logic             s_meas_valid;
   logic [2:0]       s_meas_cnt;
   logic [SW_W-1:0]  s_meas_code;

   logic [3:0]       ph;
   meas_t            exp_q[$];
   int               n_tests;
   int               n_fail;
   int               mv_count;
   int               done_count;
   int               s_mv_count;

   lc_dco_cal #(.SW_Width(SW_W), .CNT_Width(CNT_W), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)) dut (
      .ref_clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .target_cnt(target_cnt), .dco_tick(dco_tick), .sw(sw), .busy(busy), .done(done),
      .meas_valid(meas_valid), .meas_cnt(meas_cnt), .meas_code(meas_code)
   );

   lc_dco_cal #(.SW_Width(SW_W), .CNT_Width(3), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)) dut_sat (
      .ref_clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .mode(1'b0),
      .target_cnt(s_target), .dco_tick(1'b1), .sw(s_sw), .busy(s_busy), .done(s_done),
      .meas_valid(s_meas_valid), .meas_cnt(s_meas_cnt), .meas_code(s_meas_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rate(input int code);
      int r;
      r = 20 - code;
      return (r > 16) ? 16 : r;
   endfunction

   initial ph = 4'd0;
   always @(posedge clk) ph <= ph + 4'd1;
   always_comb dco_tick = (int'(ph) < rate(int'(sw)));

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Pops one expected trial per meas_valid pulse.
   always @(negedge clk) begin
      meas_t e;
      if (meas_valid) begin
         mv_count++;
         if (exp_q.size() == 0) begin
            check("meas_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("meas_code", int'(meas_code), e.code);
            check("meas_cnt", int'(meas_cnt), e.cnt);
         end
      end
      if (done) done_count++;
      if (s_meas_valid) begin
         s_mv_count++;
         check("sat_meas_cnt", int'(s_meas_cnt), 7);
      end
   end

   task automatic push_sar(input int tgt, output int fin);
      int    code;
      meas_t e;
      code = 8;
      for (int k = 3; k >= 0; k--) begin
         e.code = code;
         e.cnt  = rate(code);
         exp_q.push_back(e);
         if (!(e.cnt > tgt)) code = code & ~(1 << k);
         if (k > 0) code = code | (1 << (k - 1));
      end
      fin = code;
   endtask

   task automatic push_sweep();
      meas_t e;
      for (int c = 0; c < 16; c++) begin
         e.code = c;
         e.cnt  = rate(c);
         exp_q.push_back(e);
      end
   endtask

   // Full run: checks first-cycle state, done timing, final code and pulse counts.
   task automatic run_check(input logic m, input int tgt, input string tag, input bit poke);
      int fin, ntr, n, mv0, dn0;
      bit seen;
      if (m) begin
         push_sweep();
         fin = 15;
         ntr = 16;
      end else begin
         push_sar(tgt, fin);
         ntr = 4;
      end
      mv0 = mv_count;
      dn0 = done_count;
      mode = m;
      target_cnt = CNT_W'(tgt);
      start = 1'b1;
      seen = 1'b0;
      for (n = 1; n <= 2000; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 1) begin
            check({tag, "_busy_c1"}, int'(busy), 1);
            check({tag, "_sw_c1"}, int'(sw), m ? 0 : 8);
         end
         if (poke && (n == 30)) begin
            start = 1'b1;
            mode = ~m;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_cycle"}, seen ? n : -1, ntr * T + 2);
      check({tag, "_busy_end"}, int'(busy), 0);
      check({tag, "_sw_final"}, int'(sw), fin);
      check({tag, "_meas_pulses"}, mv_count - mv0, ntr);
      check({tag, "_q_left"}, exp_q.size(), 0);
      @(negedge clk);
      check({tag, "_done_pulses"}, done_count - dn0, 1);
      check({tag, "_sw_hold"}, int'(sw), fin);
      exp_q.delete();
   endtask

   initial begin
      int    fin, mv0, dn0, n;
      bit    seen;
      meas_t e;
      n_tests = 0; n_fail = 0; mv_count = 0; done_count = 0; s_mv_count = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; target_cnt = '0;
      s_start = 1'b0; s_target = 3'd3;
      repeat (3) @(negedge clk);
      check("rst_sw", int'(sw), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_mv", int'(meas_valid), 0);
      rst = 1'b0;
      @(negedge clk);

      // SAR calibration against two targets
      run_check(1'b0, 12, "sar12", 1'b0);
      run_check(1'b0, 14, "sar14", 1'b0);

      // Reset during the second trial's MEASURE, after one measurement landed
      e.code = 8; e.cnt = rate(8);
      exp_q.push_back(e);
      mode = 1'b0; target_cnt = CNT_W'(12); start = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_rst_mcnt", int'(meas_cnt), rate(8));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_sw", int'(sw), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_mv", int'(meas_valid), 0);
      check("mid_rst_mcnt", int'(meas_cnt), 0);
      check("mid_rst_mcode", int'(meas_code), 0);
      exp_q.delete();
      @(negedge clk);
      run_check(1'b0, 12, "after_rst", 1'b0);

      // Start pulsed mid-run must not disturb the result or timing
      run_check(1'b0, 15, "poke", 1'b1);

      // Abort during the third SAR trial
      push_sar(12, fin);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      mv0 = mv_count; dn0 = done_count;
      mode = 1'b0; target_cnt = CNT_W'(12); start = 1'b1;
      for (int i = 1; i <= 43; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_sw", int'(sw), 0);
      check("abort_busy", int'(busy), 0);
      repeat (100) @(negedge clk);
      check("abort_done", done_count - dn0, 0);
      check("abort_meas", mv_count - mv0, 2);
      check("abort_busy_late", int'(busy), 0);
      exp_q.delete();

      // start and abort together in IDLE: nothing starts
      mv0 = mv_count;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("sa_busy", int'(busy), 0);
      check("sa_sw", int'(sw), 0);
      repeat (40) @(negedge clk);
      check("sa_meas", mv_count - mv0, 0);
      check("sa_busy_late", int'(busy), 0);

      // Linear sweep over every code
      run_check(1'b1, 0, "sweep", 1'b0);

      // Saturating 3-bit counter with a tick every cycle
      s_start = 1'b1;
      seen = 1'b0;
      for (n = 1; n <= 2000; n++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("sat_done_cycle", seen ? n : -1, 4 * T + 2);
      check("sat_sw_final", int'(s_sw), 15);
      check("sat_pulses", s_mv_count, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
